mult_sequencer: RTL and testbench

- Multi-cycle shift-add multiplier controller owning the HI/LO register pair.
- Sequences the 64-bit product for MULT-class instructions and serves MFHI/MFLO reads (multcont 01/10 from the decoder).
- Raises a pipeline stall while a product is pending.
- Sits beside the ALU in the datapath; its result is muxed into the writeback value when multcont != 00.

---
 rtl/mult_sequencer_if.sv | 31 +++
 rtl/mult_sequencer.sv | 147 ++++++++++++++
 tb/tb_mult_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_sequencer_if.sv
// Bus between the decode/datapath side and the multiply sequencer.
//
// Handshake: start is a one-cycle request that the sequencer accepts on a
// rising edge only while busy=0; a start seen while busy=1 is dropped.
// stall is the back-pressure: the pipeline must hold any HI/LO read
// (multcont 01/10) while stall=1. result is valid in any cycle where stall=0.
interface mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             is_signed;
    logic [1:0]       multcont;
    logic [WIDTH-1:0] result;
    logic             stall;
    logic             busy;
    logic             done;

    // Pipeline side: issues multiplies and HI/LO reads.
    modport master (
        output start, srca, srcb, is_signed, multcont,
        input  result, stall, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, srca, srcb, is_signed, multcont,
        output result, stall, busy, done
    );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-add multiply sequencer owning the HI/LO register pair.
// Retires RADIX_BITS multiplier bits per cycle, so a product takes
// N = WIDTH/RADIX_BITS cycles regardless of operand values. RADIX_BITS must
// be 1, 2 or 4 and divide WIDTH.
// Optional feature: define MULT_SIGNED_EN to honour is_signed (sign-magnitude
// multiply with a final two's-complement negation); otherwise all products
// are unsigned and is_signed is ignored.
module mult_sequencer #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic               clk,
    input  logic               reset,
    mult_sequencer_if.slave    bus,
    output logic               state_dbg
);

    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Accumulator and the multiplicand pre-shifted to the current digit
    // position, so each step is a plain add of multiplicand * digit.
    logic [PW-1:0]         acc;
    logic [PW-1:0]         mcand_sh;
    logic [WIDTH-1:0]      mplier;
    logic [CNT_W-1:0]      count;
    logic                  neg;
    logic [WIDTH-1:0]      hi;
    logic [WIDTH-1:0]      lo;
    logic                  done_q;

    logic                  accept;
    logic                  last_step;
    logic                  read;
    logic [RADIX_BITS-1:0] digit;
    logic [PW-1:0]         pp;
    logic [PW-1:0]         acc_sum;
    logic [PW-1:0]         product;
    logic [WIDTH-1:0]      mag_a;
    logic [WIDTH-1:0]      mag_b;
    logic                  sign_in;

`ifdef MULT_SIGNED_EN
    // Signed requests multiply magnitudes and remember the result sign.
    always_comb begin
        sign_in = bus.is_signed & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
        mag_a   = (bus.is_signed && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
        mag_b   = (bus.is_signed && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
    end
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;

    // Unsigned-only build: operands pass straight through.
    always_comb begin
        sign_in = 1'b0;
        mag_a   = bus.srca;
        mag_b   = bus.srcb;
    end
`endif

    // One shift-add step and the completed product (with sign fix-up).
    always_comb begin
        digit     = mplier[RADIX_BITS-1:0];
        pp        = mcand_sh * PW'(digit);
        acc_sum   = acc + pp;
        product   = neg ? -acc_sum : acc_sum;
        accept    = (state == IDLE) && bus.start;
        last_step = (state == RUN) && (count == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE accepts a start, RUN lasts exactly N edges.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN:  if (count == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, step while running, commit HI/LO at the end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            count    <= '0;
            neg      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                acc      <= '0;
                mcand_sh <= {{WIDTH{1'b0}}, mag_a};
                mplier   <= mag_b;
                count    <= CNT_W'(N);
                neg      <= sign_in;
            end else if (state == RUN) begin
                acc      <= acc_sum;
                mcand_sh <= mcand_sh << RADIX_BITS;
                mplier   <= mplier >> RADIX_BITS;
                count    <= count - CNT_W'(1);
                if (last_step) begin
                    hi     <= product[PW-1:WIDTH];
                    lo     <= product[WIDTH-1:0];
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Read mux and stall: a read stalls while a product is pending or starting.
    always_comb begin
        read       = (bus.multcont == 2'b01) || (bus.multcont == 2'b10);
        bus.busy   = (state == RUN);
        bus.done   = done_q;
        bus.stall  = read && ((state == RUN) || bus.start);
        state_dbg  = (state == RUN);
        case (bus.multcont)
            2'b01:   bus.result = hi;
            2'b10:   bus.result = lo;
            default: bus.result = '0;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: a cycle-level reference model (product
// computed arithmetically, delivered N cycles after acceptance) checked
// against the DUT every cycle, plus literal HI/LO/latency expectations.
module tb_mult_sequencer;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int N4 = 8;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic state_dbg;
    logic state_dbg4;

    int checks   = 0;
    int failures = 0;

    // Clock.
    always #5 clk = ~clk;

    mult_sequencer_if #(.WIDTH(W)) bus ();
    mult_sequencer_if #(.WIDTH(W)) bus4 ();

    mult_sequencer #(.WIDTH(W), .RADIX_BITS(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
    );

    mult_sequencer #(.WIDTH(W), .RADIX_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .state_dbg(state_dbg4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                  input logic s);
        if (s && SIGNED_EN)
            return 64'(longint'($signed(a)) * longint'($signed(b)));
        return 64'(a) * 64'(b);
    endfunction

    // Reference model: HI/LO, pending product and remaining cycles.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_prod;
    logic        m_busy, m_done;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi <= '0; m_lo <= '0; m_prod <= '0;
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_hi   <= m_prod[63:32];
                    m_lo   <= m_prod[31:0];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end else if (bus.start) begin
                m_prod <= model_product(bus.srca, bus.srcb, bus.is_signed);
                m_busy <= 1'b1;
                m_left <= N;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (reset) begin
            logic        rd;
            logic [31:0] exp_res;
            rd = (bus.multcont == 2'b01) || (bus.multcont == 2'b10);
            exp_res = (bus.multcont == 2'b01) ? m_hi : (bus.multcont == 2'b10) ? m_lo : 32'h0;
            check("cyc_busy",  bus.busy,  m_busy);
            check("cyc_state", state_dbg, m_busy);
            check("cyc_done",  bus.done,  m_done);
            check("cyc_stall", bus.stall, rd && (m_busy || bus.start));
            check("cyc_result", bus.result, exp_res);
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.start = 1'b1; bus.srca = a; bus.srcb = b; bus.is_signed = s;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        check("done_seen", bus.done, 1'b1);
    endtask

    task automatic read_check(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [1:0] saved;
        saved = bus.multcont;
        bus.multcont = 2'b01; #1;
        check({name, "_hi"}, bus.result, exp_hi);
        check({name, "_model_hi"}, m_hi, exp_hi);
        bus.multcont = 2'b10; #1;
        check({name, "_lo"}, bus.result, exp_lo);
        check({name, "_model_lo"}, m_lo, exp_lo);
        bus.multcont = saved;
    endtask

    initial begin
        int c;
        reset = 1'b1;
        bus.start = 1'b0; bus.srca = '0; bus.srcb = '0; bus.is_signed = 1'b0; bus.multcont = 2'b00;
        bus4.start = 1'b0; bus4.srca = '0; bus4.srcb = '0; bus4.is_signed = 1'b0; bus4.multcont = 2'b00;
        #3 reset = 1'b0;
        #1;
        bus.multcont = 2'b01; #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.result, 32'h0);
        bus.multcont = 2'b00;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Basic unsigned multiply.
        issue(32'h0001_2345, 32'h0001_0000, 1'b0);
        check("basic_busy", bus.busy, 1'b1);
        wait_done(c);
        check("basic_latency", 32'(c), 32'd32);
        read_check("basic", 32'h0000_0001, 32'h2345_0000);
        tick();
        check("basic_done_pulse", bus.done, 1'b0);

        // Maximum operands; old HI visible and stalled mid-run; 11 = no read.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (5) tick();
        bus.multcont = 2'b01; #1;
        check("max_old_hi", bus.result, 32'h0000_0001);
        check("max_stall", bus.stall, 1'b1);
        bus.multcont = 2'b11; #1;
        check("mc11_result", bus.result, 32'h0);
        check("mc11_stall", bus.stall, 1'b0);
        bus.multcont = 2'b00;
        wait_done(c);
        check("max_latency", 32'(c + 5), 32'd32);
        read_check("max", 32'hFFFF_FFFE, 32'h0000_0001);
        tick();

        // Read every cycle from start; a start while busy is ignored.
        bus.multcont = 2'b01;
        issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        repeat (4) tick();
        bus.start = 1'b1; bus.srca = 32'h5; bus.srcb = 32'h5;
        tick();
        bus.start = 1'b0;
        wait_done(c);
        check("rwb_latency", 32'(c + 5), 32'd32);
        check("rwb_done_stall", bus.stall, 1'b0);
        check("rwb_done_hi", bus.result, 32'h0000_0002);
        bus.multcont = 2'b00;
        read_check("rwb", 32'h0000_0002, 32'hFFFF_FFFA);
        tick();

        // Signed request: honoured only with MULT_SIGNED_EN.
        issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        wait_done(c);
        if (SIGNED_EN) read_check("signed", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        else           read_check("signed", 32'h0000_0002, 32'hFFFF_FFFA);
        tick();
        issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        wait_done(c);
        read_check("unsigned", 32'h0000_0002, 32'hFFFF_FFFA);
        tick();

        // Reset mid-run: abandoned, HI/LO cleared, next start runs normally.
        issue(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        repeat (9) tick();
        reset = 1'b0; #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_state", state_dbg, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("midrst_no_done", bus.done, 1'b0);
        read_check("midrst", 32'h0, 32'h0);
        issue(32'h0000_0003, 32'h0000_0004, 1'b0);
        wait_done(c);
        check("post_rst_latency", 32'(c), 32'd32);
        read_check("post_rst", 32'h0, 32'h0000_000C);
        tick();

        // RADIX_BITS=4 instance: 8-cycle latency.
        bus4.start = 1'b1; bus4.srca = 32'd7; bus4.srcb = 32'd6;
        tick();
        bus4.start = 1'b0;
        c = 0;
        while (bus4.done !== 1'b1 && c < 40) begin
            tick();
            c++;
        end
        check("r4_done_seen", bus4.done, 1'b1);
        check("r4_latency", 32'(c), 32'(N4));
        bus4.multcont = 2'b01; #1;
        check("r4_hi", bus4.result, 32'h0);
        bus4.multcont = 2'b10; #1;
        check("r4_lo", bus4.result, 32'd42);
        bus4.multcont = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
